// File: rtl/ulpb_tx_arbiter.sv
// Transmit arbiter: grants one of NUM_REQ requesters the bus node (priority first,
// then round-robin) and relays the word handshakes and the message result.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ulpb_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic                             CLKIN,
  input  logic                             RESETn,
  input  logic [NUM_REQ*`ADDR_WIDTH-1:0]   REQ_TX_ADDR,
  input  logic [NUM_REQ*`DATA_WIDTH-1:0]   REQ_TX_DATA,
  input  logic [NUM_REQ-1:0]               REQ_TX_REQ,
  input  logic [NUM_REQ-1:0]               REQ_TX_PEND,
  input  logic [NUM_REQ-1:0]               REQ_PRIORITY,
  input  logic [NUM_REQ-1:0]               REQ_TX_RESP_ACK,
  output logic [NUM_REQ-1:0]               REQ_TX_ACK,
  output logic [NUM_REQ-1:0]               REQ_TX_SUCC,
  output logic [NUM_REQ-1:0]               REQ_TX_FAIL,
  output logic [`ADDR_WIDTH-1:0]           TX_ADDR,
  output logic [`DATA_WIDTH-1:0]           TX_DATA,
  output logic                             TX_REQ,
  output logic                             TX_PEND,
  output logic                             PRIORITY,
  output logic                             TX_RESP_ACK,
  input  logic                             TX_ACK,
  input  logic                             TX_SUCC,
  input  logic                             TX_FAIL,
  output logic [NUM_REQ-1:0]               GRANT,
  output logic                             BUSY
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    ACKWAIT  = 3'd2,
    NEXT     = 3'd3,
    RESP     = 3'd4,
    RESPDONE = 3'd5
  } state_t;

  state_t                   state_q;
  logic [PTR_W-1:0]         rr_ptr_q;
  logic [PTR_W-1:0]         rr_ptr_d;
  logic [PTR_W-1:0]         gidx_q;
  logic [NUM_REQ-1:0]       grant_q;
  logic [NUM_REQ-1:0]       req_ack_q;
  logic [NUM_REQ-1:0]       req_succ_q;
  logic [NUM_REQ-1:0]       req_fail_q;
  logic [`ADDR_WIDTH-1:0]   tx_addr_q;
  logic [`DATA_WIDTH-1:0]   tx_data_q;
  logic                     tx_req_q;
  logic                     tx_pend_q;
  logic                     prio_q;
  logic                     tx_resp_ack_q;
  logic                     busy_q;

  logic [NUM_REQ-1:0]       cand;
  logic [PTR_W:0]           sum;
  logic [PTR_W-1:0]         win_idx;
  logic                     win_vld;
  logic [PTR_W-1:0]         ld_idx;
  logic [`ADDR_WIDTH-1:0]   ld_addr;
  logic [`DATA_WIDTH-1:0]   ld_data;
  logic                     ld_pend;
  logic                     g_req;
  logic                     g_resp_ack;
  logic                     abort;
  logic                     res_low;

  // Priority requesters form the candidate set when present; scan from rr_ptr with wrap.
  always_comb begin
    cand    = ((REQ_TX_REQ & REQ_PRIORITY) != '0) ? (REQ_TX_REQ & REQ_PRIORITY) : REQ_TX_REQ;
    sum     = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      if (!win_vld && cand[sum[PTR_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    ld_idx     = (state_q == IDLE) ? win_idx : gidx_q;
    ld_addr    = REQ_TX_ADDR[int'(ld_idx)*`ADDR_WIDTH +: `ADDR_WIDTH];
    ld_data    = REQ_TX_DATA[int'(ld_idx)*`DATA_WIDTH +: `DATA_WIDTH];
    ld_pend    = REQ_TX_PEND[ld_idx];
    g_req      = |(REQ_TX_REQ & grant_q);
    g_resp_ack = |(REQ_TX_RESP_ACK & grant_q);
    abort      = TX_FAIL && !TX_SUCC;
    res_low    = !TX_SUCC && !TX_FAIL;
    rr_ptr_d   = (gidx_q == PTR_W'(NUM_REQ-1)) ? '0 : gidx_q + 1'b1;
  end

  always_ff @(posedge CLKIN) begin
    if (!RESETn) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      gidx_q        <= '0;
      grant_q       <= '0;
      req_ack_q     <= '0;
      req_succ_q    <= '0;
      req_fail_q    <= '0;
      tx_addr_q     <= '0;
      tx_data_q     <= '0;
      tx_req_q      <= 1'b0;
      tx_pend_q     <= 1'b0;
      prio_q        <= 1'b0;
      tx_resp_ack_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            gidx_q    <= win_idx;
            grant_q   <= NUM_REQ'(1) << win_idx;
            tx_addr_q <= ld_addr;
            tx_data_q <= ld_data;
            tx_pend_q <= ld_pend;
            prio_q    <= REQ_PRIORITY[win_idx];
            tx_req_q  <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            tx_req_q   <= 1'b0;
            tx_pend_q  <= 1'b0;
            req_fail_q <= grant_q;
            state_q    <= RESP;
          end else if (TX_ACK) begin
            tx_req_q  <= 1'b0;
            req_ack_q <= grant_q;
            state_q   <= ACKWAIT;
          end
        end
        ACKWAIT: begin
          if (abort) begin
            tx_pend_q  <= 1'b0;
            req_ack_q  <= '0;
            req_fail_q <= grant_q;
            state_q    <= RESP;
          end else begin
            if (TX_SUCC && !tx_pend_q) req_succ_q <= grant_q;
            if (!g_req && !TX_ACK) begin
              req_ack_q <= '0;
              state_q   <= tx_pend_q ? NEXT : RESP;
            end
          end
        end
        NEXT: begin
          // Grant stays locked: only the owner may supply the next word.
          if (abort) begin
            tx_pend_q  <= 1'b0;
            req_fail_q <= grant_q;
            state_q    <= RESP;
          end else if (g_req) begin
            tx_addr_q <= ld_addr;
            tx_data_q <= ld_data;
            tx_pend_q <= ld_pend;
            tx_req_q  <= 1'b1;
            state_q   <= SEND;
          end
        end
        RESP: begin
          if (TX_SUCC)      req_succ_q <= grant_q;
          else if (TX_FAIL) req_fail_q <= grant_q;
          if (g_resp_ack) begin
            tx_resp_ack_q <= 1'b1;
            state_q       <= RESPDONE;
          end
        end
        RESPDONE: begin
          if (res_low) begin
            req_succ_q <= '0;
            req_fail_q <= '0;
          end else if (TX_SUCC) begin
            req_succ_q <= grant_q;
          end else begin
            req_fail_q <= grant_q;
          end
          if (!g_resp_ack) tx_resp_ack_q <= 1'b0;
          if (res_low && !g_resp_ack) begin
            grant_q   <= '0;
            rr_ptr_q  <= rr_ptr_d;
            prio_q    <= 1'b0;
            tx_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REQ_TX_ACK  = req_ack_q;
  assign REQ_TX_SUCC = req_succ_q;
  assign REQ_TX_FAIL = req_fail_q;
  assign TX_ADDR     = tx_addr_q;
  assign TX_DATA     = tx_data_q;
  assign TX_REQ      = tx_req_q;
  assign TX_PEND     = tx_pend_q;
  assign PRIORITY    = prio_q;
  assign TX_RESP_ACK = tx_resp_ack_q;
  assign GRANT       = grant_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_ulpb_tx_arbiter.sv
// Directed bench for ulpb_tx_arbiter: round-robin, priority, multi-word lock,
// bus abort and mid-message reset, with hand-computed expectations.
module tb_ulpb_tx_arbiter;
  localparam int N = 4;

  logic            CLKIN;
  logic            RESETn;
  logic [N*8-1:0]  REQ_TX_ADDR;
  logic [N*32-1:0] REQ_TX_DATA;
  logic [N-1:0]    REQ_TX_REQ, REQ_TX_PEND, REQ_PRIORITY, REQ_TX_RESP_ACK;
  logic [N-1:0]    REQ_TX_ACK, REQ_TX_SUCC, REQ_TX_FAIL, GRANT;
  logic [7:0]      TX_ADDR;
  logic [31:0]     TX_DATA;
  logic            TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK, BUSY;
  logic            TX_ACK, TX_SUCC, TX_FAIL;

  int n_chk = 0;
  int n_err = 0;

  ulpb_tx_arbiter #(.NUM_REQ(N), .PTR_W(2)) dut (
    .CLKIN(CLKIN), .RESETn(RESETn),
    .REQ_TX_ADDR(REQ_TX_ADDR), .REQ_TX_DATA(REQ_TX_DATA),
    .REQ_TX_REQ(REQ_TX_REQ), .REQ_TX_PEND(REQ_TX_PEND),
    .REQ_PRIORITY(REQ_PRIORITY), .REQ_TX_RESP_ACK(REQ_TX_RESP_ACK),
    .REQ_TX_ACK(REQ_TX_ACK), .REQ_TX_SUCC(REQ_TX_SUCC), .REQ_TX_FAIL(REQ_TX_FAIL),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_REQ(TX_REQ), .TX_PEND(TX_PEND),
    .PRIORITY(PRIORITY), .TX_RESP_ACK(TX_RESP_ACK),
    .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
    .GRANT(GRANT), .BUSY(BUSY)
  );

  initial begin
    CLKIN = 1'b0;
    forever #5 CLKIN = ~CLKIN;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKIN);
    #1;
  endtask

  task automatic put_req(input int g, input logic [7:0] a, input logic [31:0] d,
                         input logic pend, input logic prio);
    REQ_TX_ADDR[g*8 +: 8]   = a;
    REQ_TX_DATA[g*32 +: 32] = d;
    REQ_TX_PEND[g]          = pend;
    REQ_PRIORITY[g]         = prio;
    REQ_TX_REQ[g]           = 1'b1;
  endtask

  // Node ACKs the word in SEND, then requester and node both release.
  task automatic word_hs(input int g, input bit last);
    chk("txreq_on", TX_REQ, 1);
    TX_ACK = 1'b1;
    tick();
    chk("req_ack", REQ_TX_ACK, 64'(1) << g);
    chk("txreq_off", TX_REQ, 0);
    chk("st_ackwait", dut.state_q, 2);
    TX_ACK = 1'b0;
    REQ_TX_REQ[g] = 1'b0;
    tick();
    chk("req_ack_drop", REQ_TX_ACK, 0);
    chk("st_after_word", dut.state_q, last ? 4 : 3);
  endtask

  // Result from node, response handshake, return to IDLE.
  task automatic finish_msg(input int g, input bit succ);
    if (succ) TX_SUCC = 1'b1; else TX_FAIL = 1'b1;
    tick();
    chk("succ_mirror", REQ_TX_SUCC, succ ? (64'(1) << g) : 64'(0));
    chk("fail_mirror", REQ_TX_FAIL, succ ? 64'(0) : (64'(1) << g));
    REQ_TX_RESP_ACK[g] = 1'b1;
    tick();
    chk("tx_resp_ack_on", TX_RESP_ACK, 1);
    chk("st_respdone", dut.state_q, 5);
    TX_SUCC = 1'b0;
    TX_FAIL = 1'b0;
    REQ_TX_RESP_ACK[g] = 1'b0;
    tick();
    chk("grant_clear", GRANT, 0);
    chk("busy_clear", BUSY, 0);
    chk("tx_resp_ack_off", TX_RESP_ACK, 0);
    chk("results_clear", {REQ_TX_SUCC, REQ_TX_FAIL}, 0);
  endtask

  initial begin
    RESETn = 1'b0;
    REQ_TX_ADDR = '0; REQ_TX_DATA = '0; REQ_TX_REQ = '0; REQ_TX_PEND = '0;
    REQ_PRIORITY = '0; REQ_TX_RESP_ACK = '0;
    TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
    tick();
    tick();
    chk("rst_grant", GRANT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_txreq", TX_REQ, 0);
    chk("rst_addr_data", {TX_ADDR, TX_DATA}, 0);
    chk("rst_state", dut.state_q, 0);
    chk("rst_rr", dut.rr_ptr_q, 0);
    RESETn = 1'b1;
    tick();
    chk("idle_no_req", GRANT, 0);

    // Single word from requester 2
    put_req(2, 8'h5A, 32'hDEADBEEF, 1'b0, 1'b0);
    tick();
    chk("s1_grant", GRANT, 4'b0100);
    chk("s1_addr", TX_ADDR, 8'h5A);
    chk("s1_data", TX_DATA, 32'hDEADBEEF);
    chk("s1_busy", BUSY, 1);
    chk("s1_pend", TX_PEND, 0);
    word_hs(2, 1);
    finish_msg(2, 1);
    chk("s1_rr", dut.rr_ptr_q, 3);

    // Requester 0 alone from rr_ptr=3 wraps to 0
    put_req(0, 8'h10, 32'h1111_0000, 1'b0, 1'b0);
    tick();
    chk("s1b_grant", GRANT, 4'b0001);
    word_hs(0, 1);
    finish_msg(0, 1);
    chk("s1b_rr", dut.rr_ptr_q, 1);

    // Requesters 0 and 3 together, rr_ptr=1: 3 first, then 0
    put_req(0, 8'h20, 32'h2222_0000, 1'b0, 1'b0);
    put_req(3, 8'h23, 32'h2222_0003, 1'b0, 1'b0);
    tick();
    chk("s2_grant3", GRANT, 4'b1000);
    chk("s2_addr3", TX_ADDR, 8'h23);
    word_hs(3, 1);
    chk("s2_grant3_hold", GRANT, 4'b1000);
    finish_msg(3, 1);
    chk("s2_rr0", dut.rr_ptr_q, 0);
    tick();
    chk("s2_grant0", GRANT, 4'b0001);
    chk("s2_data0", TX_DATA, 32'h2222_0000);
    word_hs(0, 1);
    finish_msg(0, 1);
    chk("s2_rr1", dut.rr_ptr_q, 1);

    // Three-word message from 0 while 1 requests
    put_req(0, 8'h30, 32'h0000_00A0, 1'b1, 1'b0);
    tick();
    chk("s4_grant_w0", GRANT, 4'b0001);
    chk("s4_pend_w0", TX_PEND, 1);
    put_req(1, 8'h31, 32'h0000_00B0, 1'b0, 1'b0);
    word_hs(0, 0);
    chk("s4_lock_next1", GRANT, 4'b0001);
    put_req(0, 8'h30, 32'h0000_00A1, 1'b1, 1'b0);
    tick();
    chk("s4_data_w1", TX_DATA, 32'h0000_00A1);
    chk("s4_grant_w1", GRANT, 4'b0001);
    word_hs(0, 0);
    chk("s4_lock_next2", GRANT, 4'b0001);
    put_req(0, 8'h30, 32'h0000_00A2, 1'b0, 1'b0);
    tick();
    chk("s4_data_w2", TX_DATA, 32'h0000_00A2);
    chk("s4_pend_w2", TX_PEND, 0);
    chk("s4_grant_w2", GRANT, 4'b0001);
    word_hs(0, 1);
    finish_msg(0, 1);
    tick();
    chk("s4_grant1", GRANT, 4'b0010);
    chk("s4_addr1", TX_ADDR, 8'h31);
    word_hs(1, 1);
    finish_msg(1, 1);
    chk("s4_rr2", dut.rr_ptr_q, 2);

    // Priority: 1 with priority beats 0 (which round-robin would favour from rr_ptr=2)
    put_req(0, 8'h40, 32'h0000_00C0, 1'b0, 1'b0);
    put_req(1, 8'h41, 32'h0000_00C1, 1'b0, 1'b1);
    tick();
    chk("s3_grant1", GRANT, 4'b0010);
    chk("s3_prio_on", PRIORITY, 1);
    REQ_PRIORITY[1] = 1'b0;
    word_hs(1, 1);
    chk("s3_prio_held", PRIORITY, 1);
    finish_msg(1, 1);
    chk("s3_prio_idle", PRIORITY, 0);
    tick();
    chk("s3_grant0", GRANT, 4'b0001);
    chk("s3_prio0", PRIORITY, 0);
    word_hs(0, 1);
    finish_msg(0, 1);
    chk("s3_rr1", dut.rr_ptr_q, 1);

    // Bus abort in NEXT after the first word
    put_req(2, 8'h50, 32'h0000_00E0, 1'b1, 1'b0);
    tick();
    chk("s5_grant", GRANT, 4'b0100);
    word_hs(2, 0);
    TX_FAIL = 1'b1;
    tick();
    chk("s5_txreq", TX_REQ, 0);
    chk("s5_pend", TX_PEND, 0);
    chk("s5_fail", REQ_TX_FAIL, 4'b0100);
    chk("s5_ack", REQ_TX_ACK, 0);
    chk("s5_state", dut.state_q, 4);
    finish_msg(2, 0);
    chk("s5_rr", dut.rr_ptr_q, 3);

    // Reset while in ACKWAIT
    put_req(0, 8'h60, 32'h0000_00F0, 1'b1, 1'b1);
    tick();
    TX_ACK = 1'b1;
    tick();
    chk("s6_ackwait", dut.state_q, 2);
    chk("s6_ack", REQ_TX_ACK, 4'b0001);
    RESETn = 1'b0;
    TX_ACK = 1'b0;
    tick();
    chk("s6_grant", GRANT, 0);
    chk("s6_busy", BUSY, 0);
    chk("s6_node_ctl", {TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK}, 0);
    chk("s6_addr_data", {TX_ADDR, TX_DATA}, 0);
    chk("s6_req_side", {REQ_TX_ACK, REQ_TX_SUCC, REQ_TX_FAIL}, 0);
    chk("s6_state", dut.state_q, 0);
    chk("s6_rr", dut.rr_ptr_q, 0);
    REQ_TX_REQ = '0;
    REQ_PRIORITY = '0;
    RESETn = 1'b1;
    tick();
    chk("s6_idle", dut.state_q, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
